// File: rtl/pixel_scan_pkg.sv
// Shared types and default widths for the pixel scan controller.
package pixel_scan_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_STEP_W = 3;
    localparam int unsigned STATE_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE,
        S_READ,
        S_WAIT_RD,
        S_DEC,
        S_WAIT_DEC,
        S_WRITE,
        S_ADV,
        S_DONE
    } scan_state_t;

endpackage

// File: rtl/pixel_scan_if.sv
// Control, RAM and decrypt handshake bundle between the scan controller and its neighbours.
interface pixel_scan_if
    import pixel_scan_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned STEP_W = DEF_STEP_W
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] out_base;
    logic [ADDR_W-1:0] pixel_count;
    logic [STEP_W-1:0] step;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic              dec_start;
    logic              dec_done;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] processed;

    // Host side: control FSM, image RAM and decrypt core.
    modport master (
        output start, abort, base_addr, out_base, pixel_count, step, rd_valid, dec_done,
        input  rd_en, rd_addr, dec_start, wr_en, wr_addr, busy, done, processed
    );

    // Controller side.
    modport slave (
        input  start, abort, base_addr, out_base, pixel_count, step, rd_valid, dec_done,
        output rd_en, rd_addr, dec_start, wr_en, wr_addr, busy, done, processed
    );
endinterface

// File: rtl/pixel_scan_controller_addr_counter.sv
// Source address counter: parallel load or step increment, otherwise hold; wraps silently.
module addr_counter
    import pixel_scan_pkg::*;
#(
    parameter int unsigned W      = DEF_ADDR_W,
    parameter int unsigned STEP_W = DEF_STEP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [W-1:0]      i_load_val,
    input  logic              i_inc,
    input  logic [STEP_W-1:0] i_step,
    output logic [W-1:0]      o_count
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc) begin
            r_count <= r_count + W'(i_step);
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/pixel_scan_controller.sv
// Walks a pixel region: read, decrypt, write, advance; one transaction in flight at a time.
module pixel_scan_controller
    import pixel_scan_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned STEP_W = DEF_STEP_W
) (
    input  logic       clk,
    input  logic       rst,
    pixel_scan_if.slave bus
);
    scan_state_t       r_state;
    scan_state_t       w_next;
    logic              w_load;
    logic              w_inc;
    logic [ADDR_W-1:0] w_addr;

    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_out_base;
    logic [ADDR_W-1:0] r_pix_count;
    logic [STEP_W-1:0] r_step;
    logic [ADDR_W-1:0] r_processed;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_rd_en;
    logic              r_dec_start;
    logic              r_wr_en;
    logic              r_busy;
    logic              r_done;

    addr_counter #(.W(ADDR_W), .STEP_W(STEP_W)) u_addr_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (bus.base_addr),
        .i_inc      (w_inc),
        .i_step     (r_step),
        .o_count    (w_addr)
    );

    // Next state and counter control; abort overrides every handshake outside IDLE.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_inc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_load = 1'b1;
                    w_next = (bus.pixel_count == '0) ? S_DONE : S_READ;
                end
            end
            S_READ:     w_next = S_WAIT_RD;
            S_WAIT_RD:  if (bus.rd_valid) w_next = S_DEC;
            S_DEC:      w_next = S_WAIT_DEC;
            S_WAIT_DEC: if (bus.dec_done) w_next = S_WRITE;
            S_WRITE:    w_next = S_ADV;
            S_ADV: begin
                if (r_processed == r_pix_count) begin
                    w_next = S_DONE;
                end else begin
                    w_inc  = 1'b1;
                    w_next = S_READ;
                end
            end
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
        if ((r_state != S_IDLE) && bus.abort) begin
            w_next = S_IDLE;
            w_inc  = 1'b0;
        end
    end

    // Strobes are registered from the next state so they coincide with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_out_base  <= '0;
            r_pix_count <= '0;
            r_step      <= '0;
            r_processed <= '0;
            r_wr_addr   <= '0;
            r_rd_en     <= 1'b0;
            r_dec_start <= 1'b0;
            r_wr_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_rd_en     <= (w_next == S_READ);
            r_dec_start <= (w_next == S_DEC);
            r_wr_en     <= (w_next == S_WRITE);
            r_busy      <= (w_next != S_IDLE);
            r_done      <= (w_next == S_DONE);
            if (w_load) begin
                r_base      <= bus.base_addr;
                r_out_base  <= bus.out_base;
                r_pix_count <= bus.pixel_count;
                r_step      <= bus.step;
                r_processed <= '0;
            end
            if (w_next == S_WRITE) begin
                r_wr_addr   <= r_out_base + (w_addr - r_base);
                r_processed <= r_processed + ADDR_W'(1);
            end
        end
    end

    assign bus.rd_en     = r_rd_en;
    assign bus.rd_addr   = w_addr;
    assign bus.dec_start = r_dec_start;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.processed = r_processed;
endmodule
